misc_issue_ctrl: RTL and testbench

- In-order issue controller and serializer in front of the misc (branch/privileged) execution pipe.
- Buffers dispatched misc micro-ops in a small FIFO and issues them to the pipe via valid/ready.
- Issues a privileged op only when it is at the ROB head and the pipe has drained; then holds all further issue until that op's writeback handshake completes.
- Sits between rename/dispatch and the misc pipe; commit side supplies ROB head.

---
 rtl/misc_issue_pkg.sv | 20 ++
 rtl/misc_issue_fifo.sv | 65 ++++++
 rtl/misc_issue_ctrl.sv | 119 +++++++++++
 tb/tb_misc_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misc_issue_pkg.sv
// Shared types for the misc-pipe issue controller: FSM state encoding and
// the FIFO entry layout that travels from dispatch to the issue port.
package misc_issue_pkg;

    localparam int MISC_PAYLOAD_W = 128;
    localparam int MISC_ROB_IDX_W = 6;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_HEAD = 2'd1,
        PRIV_BUSY = 2'd2
    } misc_issue_state_e;

    typedef struct packed {
        logic [MISC_PAYLOAD_W-1:0] payload;
        logic                      priv;
        logic [MISC_ROB_IDX_W-1:0] rob_idx;
    } misc_issue_entry_t;

endpackage

// File: rtl/misc_issue_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data is presented combinationally.
// Full blocks pushes even when a pop happens in the same cycle.
module misc_issue_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && pop_i && !flush_i && do_push));
    a_ptr_span: assert property (@(posedge clk) disable iff (!rst_n)
        ((wr_ptr_q - rd_ptr_q) <= (AW+1)'(DEPTH)));

endmodule

// File: rtl/misc_issue_ctrl.sv
// In-order issue controller for the misc pipe: buffers dispatched ops, serialises
// privileged ops behind ROB-head + drained pipe, and blocks issue until their writeback.
module misc_issue_ctrl
    import misc_issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = MISC_PAYLOAD_W,
    parameter int ROB_IDX_W = MISC_ROB_IDX_W,
    parameter int INFL_MAX  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 disp_valid_i,
    output logic                 disp_ready_o,
    input  logic [PAYLOAD_W-1:0] disp_payload_i,
    input  logic                 disp_priv_i,
    input  logic [ROB_IDX_W-1:0] disp_rob_idx_i,
    input  logic [ROB_IDX_W-1:0] rob_head_idx_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output logic [PAYLOAD_W-1:0] iss_payload_o,
    output logic                 iss_priv_o,
    output logic [ROB_IDX_W-1:0] iss_rob_idx_o,
    input  logic                 wb_valid_i,
    input  logic                 wb_ready_i,
    input  logic                 wb_priv_i,
    output logic                 busy_o
);

    localparam int              CNT_W      = $clog2(INFL_MAX + 1);
    localparam logic [CNT_W-1:0] INFL_MAX_C = CNT_W'(INFL_MAX);
    localparam int              ENTRY_W    = $bits(misc_issue_entry_t);

    misc_issue_state_e state_q, state_d;
    logic [CNT_W-1:0]  infl_q, infl_d;
    misc_issue_entry_t wr_entry, head;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              iss_fire, wb_fire;

    assign wr_entry = '{payload: disp_payload_i, priv: disp_priv_i, rob_idx: disp_rob_idx_i};
    assign head     = fifo_rdata;

    misc_issue_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (disp_valid_i),
        .pop_i   (iss_fire),
        .wdata_i (wr_entry),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign disp_ready_o  = !fifo_full;
    assign iss_payload_o = head.payload;
    assign iss_priv_o    = head.priv;
    assign iss_rob_idx_o = head.rob_idx;

    assign iss_fire = iss_valid_o && iss_ready_i;
    assign wb_fire  = wb_valid_i && wb_ready_i;

    always_comb begin
        state_d     = state_q;
        iss_valid_o = 1'b0;
        case (state_q)
            RUN: begin
                if (!fifo_empty) begin
                    if (head.priv) state_d     = WAIT_HEAD;
                    else           iss_valid_o = (infl_q < INFL_MAX_C);
                end
            end
            WAIT_HEAD: begin
                // Privileged op must be the oldest uncommitted op with an empty pipe.
                iss_valid_o = !fifo_empty && (rob_head_idx_i == head.rob_idx) &&
                              (infl_q == '0);
                if (iss_valid_o && iss_ready_i) state_d = PRIV_BUSY;
            end
            PRIV_BUSY: begin
                if (wb_fire && wb_priv_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (flush_i) state_d = RUN;
    end

    always_comb begin
        infl_d = infl_q;
        case ({iss_fire, wb_fire})
            2'b10:   infl_d = infl_q + CNT_W'(1);
            2'b01:   infl_d = infl_q - CNT_W'(1);
            default: infl_d = infl_q;
        endcase
        if (flush_i) infl_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
        end
    end

    assign busy_o = !fifo_empty || (infl_q != '0) || (state_q != RUN);

    a_infl_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(!flush_i && iss_fire && !wb_fire && infl_q == INFL_MAX_C));
    a_infl_unf: assert property (@(posedge clk) disable iff (!rst_n)
        !(!flush_i && wb_fire && !iss_fire && infl_q == '0));

endmodule

// File: tb/tb_misc_issue_ctrl.sv
// Directed bench for misc_issue_ctrl: vector tables plus hand-written multi-cycle sequences.
module tb_misc_issue_ctrl;

    logic         clk, rst_n, flush_i;
    logic         disp_valid_i, disp_ready_o, disp_priv_i;
    logic [127:0] disp_payload_i, iss_payload_o;
    logic [5:0]   disp_rob_idx_i, rob_head_idx_i, iss_rob_idx_o;
    logic         iss_valid_o, iss_ready_i, iss_priv_o;
    logic         wb_valid_i, wb_ready_i, wb_priv_i, busy_o;

    int checks = 0;
    int errors = 0;
    int infl_m = 0;
    int exp_q[$];

    typedef struct {
        logic       dv, pr;
        logic [5:0] rob, rh;
        logic       ir, wbv, wbr, wbp;
        logic       e_dr, e_iv;
        logic [5:0] e_rob;
        logic       e_pr, e_busy;
    } vec_t;
    vec_t vecs[$];

    misc_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_payload_i(disp_payload_i), .disp_priv_i(disp_priv_i),
        .disp_rob_idx_i(disp_rob_idx_i), .rob_head_idx_i(rob_head_idx_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_payload_o(iss_payload_o), .iss_priv_o(iss_priv_o),
        .iss_rob_idx_o(iss_rob_idx_o), .wb_valid_i(wb_valid_i),
        .wb_ready_i(wb_ready_i), .wb_priv_i(wb_priv_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pl(input logic [5:0] r);
        return {16{2'b10, r}};
    endfunction

    function automatic vec_t mkv(input logic dv, pr, input logic [5:0] rob, rh,
                                 input logic ir, wbv, wbr, wbp, e_dr, e_iv,
                                 input logic [5:0] e_rob, input logic e_pr, e_busy);
        vec_t v;
        v.dv = dv; v.pr = pr; v.rob = rob; v.rh = rh; v.ir = ir;
        v.wbv = wbv; v.wbr = wbr; v.wbp = wbp; v.e_dr = e_dr; v.e_iv = e_iv;
        v.e_rob = e_rob; v.e_pr = e_pr; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic dv, pr, input logic [5:0] rob, rh,
                         input logic ir, wbv, wbr, wbp, fl);
        disp_valid_i   = dv;
        disp_priv_i    = pr;
        disp_rob_idx_i = rob;
        disp_payload_i = pl(rob);
        rob_head_idx_i = rh;
        iss_ready_i    = ir;
        wb_valid_i     = wbv;
        wb_ready_i     = wbr;
        wb_priv_i      = wbp;
        flush_i        = fl;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].dv, vecs[i].pr, vecs[i].rob, vecs[i].rh, vecs[i].ir,
                  vecs[i].wbv, vecs[i].wbr, vecs[i].wbp, 1'b0);
            #1;
            chk($sformatf("%s[%0d] disp_ready", tag, i), disp_ready_o, vecs[i].e_dr);
            chk($sformatf("%s[%0d] iss_valid", tag, i), iss_valid_o, vecs[i].e_iv);
            chk($sformatf("%s[%0d] busy", tag, i), busy_o, vecs[i].e_busy);
            if (vecs[i].e_iv) begin
                chk($sformatf("%s[%0d] iss_rob", tag, i), iss_rob_idx_o, vecs[i].e_rob);
                chk($sformatf("%s[%0d] iss_priv", tag, i), iss_priv_o, vecs[i].e_pr);
                chk($sformatf("%s[%0d] iss_payload", tag, i), iss_payload_o, pl(vecs[i].e_rob));
            end
            step();
        end
        vecs.delete();
    endtask

    // Issue everything queued with ready high, returning writebacks while ops are in flight.
    task automatic drain(input string tag);
        int   got;
        logic wbv;
        logic fire;
        got = 0;
        for (int cyc = 0; cyc < 40 && !(got == exp_q.size() && infl_m == 0); cyc++) begin
            wbv = (infl_m > 0);
            drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, wbv, 1'b1, 1'b0, 1'b0);
            #1;
            fire = iss_valid_o;
            if (fire === 1'b1) begin
                if (got < exp_q.size())
                    chk($sformatf("%s order[%0d]", tag, got), iss_rob_idx_o, 128'(exp_q[got]));
                else
                    chk($sformatf("%s extra issue", tag), iss_valid_o, 1'b0);
                got++;
                infl_m++;
            end
            if (wbv) infl_m--;
            step();
        end
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk($sformatf("%s issued count", tag), 128'(got), 128'(exp_q.size()));
        chk($sformatf("%s busy after drain", tag), busy_o, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset disp_ready", disp_ready_o, 1'b1);
        chk("reset iss_valid", iss_valid_o, 1'b0);
        chk("reset busy", busy_o, 1'b0);
        #10 rst_n = 1'b1;
        step();

        // Non-priv stream with late writebacks: cap at 3 in flight holds rob 4.
        vecs.push_back(mkv(1,0,1,0,1,0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(1,0,2,0,1,0,0,0, 1,1,1,0,1));
        vecs.push_back(mkv(1,0,3,0,1,0,0,0, 1,1,2,0,1));
        vecs.push_back(mkv(1,0,4,0,1,0,0,0, 1,1,3,0,1));
        vecs.push_back(mkv(0,0,0,0,1,1,1,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,0,1,1,1,0, 1,1,4,0,1));
        vecs.push_back(mkv(0,0,0,0,1,1,1,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,0,1,1,1,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,0,1,0,0,0, 1,0,0,0,0));
        run_vecs("stream");

        // Priv gating and barrier: branch 7, priv 8, branch 9.
        vecs.push_back(mkv(1,0,7,7,1,0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(1,1,8,7,1,0,0,0, 1,1,7,0,1));
        vecs.push_back(mkv(1,0,9,7,1,0,0,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,8,1,1,1,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,7,1,0,0,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,8,0,0,0,0, 1,1,8,1,1));
        vecs.push_back(mkv(0,0,0,8,1,0,0,0, 1,1,8,1,1));
        vecs.push_back(mkv(0,0,0,9,1,0,0,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,9,1,1,0,1, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,9,1,1,1,1, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,9,1,0,0,0, 1,1,9,0,1));
        vecs.push_back(mkv(0,0,0,9,1,1,1,0, 1,0,0,0,1));
        vecs.push_back(mkv(0,0,0,9,1,0,0,0, 1,0,0,0,0));
        run_vecs("priv");

        // Full FIFO: no push while full even with a same-cycle pop.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 6'(20 + k), 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("full push%0d ready", k), disp_ready_o, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 6'd24, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full ready low", disp_ready_o, 1'b0);
        chk("full head valid", iss_valid_o, 1'b1);
        chk("full head rob", iss_rob_idx_o, 6'd20);
        step();
        drive(1'b1, 1'b0, 6'd24, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full pop ready still low", disp_ready_o, 1'b0);
        chk("full pop rob", iss_rob_idx_o, 6'd20);
        step();
        infl_m = 1;
        drive(1'b1, 1'b0, 6'd24, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full after pop ready", disp_ready_o, 1'b1);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full again ready", disp_ready_o, 1'b0);
        exp_q = '{21, 22, 23, 24};
        drain("full drain");

        // Flush in WAIT_HEAD with 3 entries and 1 in flight; same-cycle dispatch dropped.
        drive(1'b1, 1'b0, 6'd30, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 6'd31, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush setup rob30", iss_rob_idx_o, 6'd30);
        step();
        drive(1'b1, 1'b0, 6'd32, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush setup priv held", iss_valid_o, 1'b0);
        step();
        drive(1'b1, 1'b0, 6'd33, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush setup wait", iss_valid_o, 1'b0);
        step();
        drive(1'b1, 1'b0, 6'd34, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("flush pre busy", busy_o, 1'b1);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush busy", busy_o, 1'b0);
        chk("flush iss_valid", iss_valid_o, 1'b0);
        chk("flush disp_ready", disp_ready_o, 1'b1);
        step();
        drive(1'b1, 1'b0, 6'd35, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush next valid", iss_valid_o, 1'b1);
        chk("flush next rob", iss_rob_idx_o, 6'd35);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("flush dropped dispatch", iss_valid_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush idle busy", busy_o, 1'b0);

        // Async reset while in PRIV_BUSY with a branch queued behind.
        drive(1'b1, 1'b1, 6'd40, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arst priv wait", iss_valid_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arst priv issue", iss_valid_o, 1'b1);
        chk("arst priv flag", iss_priv_o, 1'b1);
        step();
        drive(1'b1, 1'b0, 6'd41, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arst priv barrier", iss_valid_o, 1'b0);
        chk("arst pre busy", busy_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst busy", busy_o, 1'b0);
        chk("arst iss_valid", iss_valid_o, 1'b0);
        chk("arst disp_ready", disp_ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 6'd42, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arst after idle", iss_valid_o, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("arst after rob42", iss_rob_idx_o, 6'd42);
        chk("arst after valid", iss_valid_o, 1'b1);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("final busy", busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
